mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 117 +++++++++++
 tb/tb_mem_port_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (fetch, data) for one shared single-port BRAM with 1-cycle read latency.
// Optional macro ARB_ROUND_ROBIN_EN: ties alternate; otherwise the data requester always wins ties.
module mem_port_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 48
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ack,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_q,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state;
  logic              mem_we_r;
  logic              f_ack_r;
  logic              d_ack_r;
  logic              win_data_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_data_r;
  logic              pick_data;
`ifdef ARB_ROUND_ROBIN_EN
  logic              last_data_r;
`endif

  always_comb begin
    pick_data = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    pick_data = d_req & (~f_req | ~last_data_r);
`else
    pick_data = d_req;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      mem_we_r   <= 1'b0;
      f_ack_r    <= 1'b0;
      d_ack_r    <= 1'b0;
      win_data_r <= 1'b0;
      mem_addr_r <= {ADDR_W{1'b0}};
      mem_data_r <= {DATA_W{1'b0}};
`ifdef ARB_ROUND_ROBIN_EN
      last_data_r <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          f_ack_r <= 1'b0;
          d_ack_r <= 1'b0;
          if (f_req || d_req) begin
            // Latch the winner's request so later input changes cannot disturb this access.
            win_data_r <= pick_data;
            mem_addr_r <= pick_data ? d_addr : f_addr;
            mem_data_r <= pick_data ? d_wdata : mem_data_r;
            mem_we_r   <= pick_data & d_we;
`ifdef ARB_ROUND_ROBIN_EN
            last_data_r <= pick_data;
`endif
            state <= ACCESS;
          end else begin
            mem_we_r <= 1'b0;
            state    <= IDLE;
          end
        end
        ACCESS: begin
          mem_we_r <= 1'b0;
          f_ack_r  <= ~win_data_r;
          d_ack_r  <= win_data_r;
          state    <= RESP;
        end
        RESP: begin
          mem_we_r <= 1'b0;
          f_ack_r  <= 1'b0;
          d_ack_r  <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          mem_we_r <= 1'b0;
          f_ack_r  <= 1'b0;
          d_ack_r  <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  // Reset masks the outputs immediately, so a reset in ACCESS kills the write and in RESP kills the ack.
  assign mem_we   = mem_we_r & ~reset;
  assign mem_addr = reset ? {ADDR_W{1'b0}} : mem_addr_r;
  assign mem_data = reset ? {DATA_W{1'b0}} : mem_data_r;
  assign f_ack    = f_ack_r & ~reset;
  assign d_ack    = d_ack_r & ~reset;
  assign f_rdata  = (f_ack_r & ~reset) ? mem_q : {DATA_W{1'b0}};
  assign d_rdata  = (d_ack_r & ~reset) ? mem_q : {DATA_W{1'b0}};
  assign busy     = (state != IDLE) & ~reset;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a behavioural 1-cycle-latency BRAM.
module tb_mem_port_arbiter;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 48;

  logic              clk = 1'b0;
  logic              reset;
  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_ack;
  logic [DATA_W-1:0] f_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_we;
  logic [DATA_W-1:0] mem_q;
  logic              busy;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  int tests = 0;
  int fails = 0;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .mem_q(mem_q),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Read-first synchronous BRAM.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_data;
    mem_q <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    f_req = 1'b0; d_req = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic exp_f;
    logic exp_d;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 48'h0;
    mem[3] = 48'h333;
    mem[5] = 48'hABC;
    mem[6] = 48'h666;
    reset = 1'b1; f_req = 1'b0; f_addr = 10'd0; d_req = 1'b0; d_we = 1'b0;
    d_addr = 10'd0; d_wdata = 48'h0;
    tick();
    tick();
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_acks", {62'd0, f_ack, d_ack}, 64'd0);
    check("rst_mem_we", {63'd0, mem_we}, 64'd0);
    check("rst_mem_addr", {54'd0, mem_addr}, 64'd0);
    check("rst_rdata", {16'd0, f_rdata | d_rdata}, 64'd0);
    reset = 1'b0;
    tick();

    // Single fetch
    f_req = 1'b1; f_addr = 10'd5;
    tick();
    check("fetch_busy_n1", {63'd0, busy}, 64'd1);
    check("fetch_noack_n1", {63'd0, f_ack}, 64'd0);
    tick();
    check("fetch_busy_n2", {63'd0, busy}, 64'd1);
    check("fetch_ack", {63'd0, f_ack}, 64'd1);
    check("fetch_rdata", {16'd0, f_rdata}, 64'hABC);
    check("fetch_d_rdata0", {16'd0, d_rdata}, 64'd0);
    f_req = 1'b0;
    tick();
    check("fetch_idle", {62'd0, busy, f_ack}, 64'd0);

    // Data write then read
    d_req = 1'b1; d_we = 1'b1; d_addr = 10'd9; d_wdata = 48'h1234;
    tick();
    check("wr_mem_we_n1", {63'd0, mem_we}, 64'd1);
    check("wr_mem_addr", {54'd0, mem_addr}, 64'd9);
    check("wr_mem_data", {16'd0, mem_data}, 64'h1234);
    tick();
    check("wr_mem_we_n2", {63'd0, mem_we}, 64'd0);
    check("wr_d_ack", {63'd0, d_ack}, 64'd1);
    d_req = 1'b0; d_we = 1'b0;
    tick();
    check("wr_hold_addr", {54'd0, mem_addr}, 64'd9);
    d_req = 1'b1; d_addr = 10'd9;
    tick();
    tick();
    check("rd_d_ack", {63'd0, d_ack}, 64'd1);
    check("rd_d_rdata", {16'd0, d_rdata}, 64'h1234);
    check("rd_f_rdata0", {16'd0, f_rdata}, 64'd0);
    d_req = 1'b0;
    tick();

    // Tie arbitration right after reset
    do_reset();
    f_req = 1'b1; f_addr = 10'd5; d_req = 1'b1; d_we = 1'b0; d_addr = 10'd9;
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp_f = 1'b0;
      exp_d = 1'b0;
      if (k % 3 == 2) begin
`ifdef ARB_ROUND_ROBIN_EN
        if (((k - 2) / 3) % 2 == 0) exp_f = 1'b1;
        else exp_d = 1'b1;
`else
        exp_d = 1'b1;
`endif
      end
      check($sformatf("tie_acks_c%0d", k), {62'd0, f_ack, d_ack}, {62'd0, exp_f, exp_d});
    end
    f_req = 1'b0; d_req = 1'b0;
    tick();
    tick();
    tick();

    // Reset during ACCESS of a write
    d_req = 1'b1; d_we = 1'b1; d_addr = 10'd3; d_wdata = 48'h999;
    tick();
    reset = 1'b1; d_req = 1'b0; d_we = 1'b0;
    #1;
    check("rstw_mem_we", {63'd0, mem_we}, 64'd0);
    tick();
    reset = 1'b0;
    #1;
    check("rstw_idle", {63'd0, busy}, 64'd0);
    check("rstw_no_ack", {63'd0, d_ack}, 64'd0);
    check("rstw_mem3", {16'd0, mem[3]}, 64'h333);
    tick();
    check("rstw_no_ack2", {63'd0, d_ack}, 64'd0);

    // Reset during RESP cancels the ack
    f_req = 1'b1; f_addr = 10'd5;
    tick();
    tick();
    reset = 1'b1; f_req = 1'b0;
    #1;
    check("rstr_f_ack", {63'd0, f_ack}, 64'd0);
    tick();
    reset = 1'b0;
    tick();

    // Address change in flight is ignored
    f_req = 1'b1; f_addr = 10'd5;
    tick();
    f_addr = 10'd6;
    tick();
    check("inflight_ack", {63'd0, f_ack}, 64'd1);
    check("inflight_rdata", {16'd0, f_rdata}, 64'hABC);
    f_req = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
